// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared definitions for the LCD command sequencer:
//   - lcd_state_e : sequencer FSM states
//   - CMD_*       : HD44780 command bytes used by the sequencer
//   - INIT_LEN    : number of bytes in the power-up initialisation ROM
//   - init_rom()  : initialisation byte for a given ROM index
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_POWERUP   = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_DELAY     = 3'd3,
      ST_IDLE      = 3'd4
   } lcd_state_e;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
   localparam logic [7:0] CMD_DISP_OFF = 8'h08;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;  // needs the long execution delay
   localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
   localparam logic [7:0] CMD_LINE1    = 8'h80;  // DDRAM address 0x00
   localparam logic [7:0] CMD_LINE2    = 8'hC0;  // DDRAM address 0x40

   localparam int INIT_LEN = 7;

   // Function set is sent three times: the controller may still be in
   // 4-bit mode after a warm restart, and repeating it resynchronises it.
   function automatic logic [7:0] init_rom(input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0, 3'd1, 3'd2: b = CMD_FUNC_SET;
         3'd3:             b = CMD_DISP_OFF;
         3'd4:             b = CMD_CLEAR;
         3'd5:             b = CMD_ENTRY;
         default:          b = CMD_DISP_ON;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// lcd_delay_timer
// Down-counter shared by the power-up wait and the post-command delay.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   load        : load load_value into the counter this cycle
//   load_value  : cycles to wait minus one
//   expired     : counter has reached zero (held there, no wrap)
// The reset value is a parameter so the power-up wait starts counting
// the moment reset is released, without needing a load.
module lcd_delay_timer #(
   parameter int                CNT_W       = 21,
   parameter logic [CNT_W-1:0]  RESET_VALUE = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [CNT_W-1:0]  load_value,
   output logic              expired
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= RESET_VALUE;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer
// Drives the LCD byte-send FSM: runs the HD44780 8-bit initialisation after
// power-up, then writes printable characters, tracking the cursor over a
// 2-line display and inserting DDRAM address commands at line wrap.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   char_valid/char_data  : character offered by upstream
//   char_ready            : character accepted this cycle (IDLE, no clear)
//   clear_req             : level request for clear + home, sampled in IDLE
//   init_done             : initialisation finished; held until reset
//   cmd_ready             : one-cycle request to the send FSM
//   cmd_rs/cmd_rw/cmd_data: byte and register select for the send FSM
//   cmd_done              : one-cycle completion pulse from the send FSM
module lcd_cmd_sequencer
   import lcd_pkg::*;
#(
   parameter int POWERUP_CYCLES = 750000,
   parameter int SHORT_CYCLES   = 2000,
   parameter int LONG_CYCLES    = 82000,
   parameter int COLS           = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       char_valid,
   input  logic [7:0] char_data,
   output logic       char_ready,
   input  logic       clear_req,
   output logic       init_done,
   output logic       cmd_ready,
   output logic       cmd_rs,
   output logic       cmd_rw,
   output logic [7:0] cmd_data,
   input  logic       cmd_done
);

   localparam int MAX_PS  = (POWERUP_CYCLES > SHORT_CYCLES) ? POWERUP_CYCLES : SHORT_CYCLES;
   localparam int MAX_CYC = (MAX_PS > LONG_CYCLES) ? MAX_PS : LONG_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;
   localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;

   // The timer holds "cycles minus one" so that DELAY lasts exactly the
   // parameterised number of cycles (expiry is seen in the last of them).
   localparam logic [CNT_W-1:0] POWERUP_LD = CNT_W'(POWERUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] SHORT_LD   = CNT_W'(SHORT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_LD    = CNT_W'(LONG_CYCLES - 1);
   localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
   localparam logic [2:0]       LAST_INIT  = 3'(INIT_LEN - 1);

   lcd_state_e       state;
   logic [2:0]       init_idx;
   logic             row;
   logic [COL_W-1:0] col;
   logic             addr_pend;
   logic             timer_load;
   logic [CNT_W-1:0] timer_value;
   logic             timer_expired;

   // The delay is armed on the done pulse; cmd_rs/cmd_data still describe
   // the byte just completed because they only change on entry to ISSUE.
   assign timer_load  = (state == ST_WAIT_DONE) && cmd_done;
   assign timer_value = (!cmd_rs && cmd_data == CMD_CLEAR) ? LONG_LD : SHORT_LD;

   assign cmd_ready  = (state == ST_ISSUE);
   assign char_ready = (state == ST_IDLE) && !clear_req;
   assign cmd_rw     = 1'b0;

   lcd_delay_timer #(
      .CNT_W       (CNT_W),
      .RESET_VALUE (POWERUP_LD)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .expired    (timer_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_POWERUP;
         init_idx  <= 3'd0;
         row       <= 1'b0;
         col       <= '0;
         addr_pend <= 1'b0;
         init_done <= 1'b0;
         cmd_rs    <= 1'b0;
         cmd_data  <= 8'h00;
      end else begin
         case (state)
            ST_POWERUP: begin
               if (timer_expired) begin
                  state    <= ST_ISSUE;
                  init_idx <= 3'd0;
                  cmd_rs   <= 1'b0;
                  cmd_data <= init_rom(3'd0);
               end
            end

            ST_ISSUE: begin
               state <= ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
               if (cmd_done) begin
                  state <= ST_DELAY;
               end
            end

            ST_DELAY: begin
               if (timer_expired) begin
                  if (!init_done && init_idx != LAST_INIT) begin
                     state    <= ST_ISSUE;
                     init_idx <= init_idx + 3'd1;
                     cmd_rs   <= 1'b0;
                     cmd_data <= init_rom(init_idx + 3'd1);
                  end else if (addr_pend) begin
                     // row was already toggled when the wrap was recorded
                     state     <= ST_ISSUE;
                     addr_pend <= 1'b0;
                     cmd_rs    <= 1'b0;
                     cmd_data  <= row ? CMD_LINE2 : CMD_LINE1;
                  end else begin
                     state     <= ST_IDLE;
                     init_done <= 1'b1;
                  end
               end
            end

            ST_IDLE: begin
               if (clear_req) begin
                  state     <= ST_ISSUE;
                  cmd_rs    <= 1'b0;
                  cmd_data  <= CMD_CLEAR;
                  row       <= 1'b0;
                  col       <= '0;
                  addr_pend <= 1'b0;
               end else if (char_valid) begin
                  state    <= ST_ISSUE;
                  cmd_rs   <= 1'b1;
                  cmd_data <= char_data;
                  if (col == LAST_COL) begin
                     col       <= '0;
                     row       <= ~row;
                     addr_pend <= 1'b1;
                  end else begin
                     col <= col + COL_W'(1);
                  end
               end
            end

            default: begin
               state <= ST_POWERUP;
            end
         endcase
      end
   end

endmodule

// File: doc/lcd_cmd_sequencer.md
# lcd_cmd_sequencer

Command sequencer sitting directly upstream of the LCD byte-send FSM. At power-up it runs the HD44780 8-bit initialisation sequence, then accepts printable characters over a valid/ready port. It issues each character as a data write, tracks the cursor on a 2-line display, and inserts DDRAM set-address commands at line wrap. Every byte is handed to the send FSM with a one-cycle request, and the sequencer waits for that FSM's done pulse. It then enforces the controller execution delay before issuing the next byte.

## Interface
- POWERUP_CYCLES, 750000: wait after reset before the first command (15 ms at 50 MHz).
- SHORT_CYCLES, 2000: post-command delay for ordinary commands and data (40 us).
- LONG_CYCLES, 82000: post-command delay for clear display 0x01 (1.64 ms).
- COLS, 16: characters per line.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- char_valid  in  1  character byte offered.
- char_data  in  8  character code.
- char_ready  out  1  sequencer accepts char_data this cycle.
- clear_req  in  1  request clear and home (level, sampled in IDLE).
- init_done  out  1  initialisation complete; stays high until reset.
- cmd_ready  out  1  one-cycle request to the send FSM (its dataReady input).
- cmd_rs  out  1  0 = command, 1 = data.
- cmd_rw  out  1  constant 0 (write only).
- cmd_data  out  8  byte to send.
- cmd_done  in  1  one-cycle done pulse from the send FSM (its dataDone output).

## Operation
- States: POWERUP, ISSUE, WAIT_DONE, DELAY, IDLE.
- POWERUP: counts POWERUP_CYCLES, then goes to ISSUE with init index 0.
- Init ROM, in order: 0x38, 0x38, 0x38, 0x08, 0x01 (long delay), 0x06, 0x0C. All bytes use rs=0.
- ISSUE: cmd_ready=1 for exactly one cycle, then WAIT_DONE.
- WAIT_DONE: holds until cmd_done=1, then DELAY. The delay counter loads LONG_CYCLES if the byte was 0x01, otherwise SHORT_CYCLES.
- DELAY: when the count expires:
  - if an init byte remains, increment the index and go to ISSUE;
  - else if addr_pend is set, go to ISSUE with the address command;
  - else go to IDLE, setting init_done when leaving the last init byte.
- IDLE: char_ready=1 only here, and only with clear_req=0.
  - clear_req has priority: issue 0x01 with rs=0, reset the cursor to row 0, col 0, clear addr_pend.
  - char_valid with char_ready: latch char_data, issue it with rs=1, increment col.
- Line wrap: after writing col COLS-1, set col=0, toggle row and set addr_pend. The address command is 0xC0 when the new row is 1 and 0x80 when it is 0 (wrap to top).
- cmd_rs and cmd_data are registered. They change only on entry to ISSUE and hold stable through WAIT_DONE and DELAY, because the send FSM passes them through combinationally.
- cmd_done outside WAIT_DONE is ignored.
- Counter width is $clog2 of the largest of the three delay parameters, plus 1. The counter decrements to 0 with no wrap.

## Timing
- Reset values: state POWERUP, char_ready=0, init_done=0, cmd_ready=0, cmd_rs=0, cmd_rw=0, cmd_data=0x00, cursor row 0 / col 0, addr_pend=0.
- Reset mid-operation aborts any byte and restarts POWERUP. No partial command is retried.
- cmd_ready is never high two consecutive cycles. Only one byte is outstanding at a time.
- Character latency, with acceptance at cycle 0:
  - cycle 1: ISSUE, cmd_ready=1;
  - cycles 2-4: WAIT_DONE, cmd_done expected at cycle 4;
  - cycles 5 to 4+SHORT_CYCLES: DELAY;
  - cycle 5+SHORT_CYCLES: IDLE, char_ready=1.
- A wrap character adds one full ISSUE/WAIT_DONE/DELAY cycle for the address command before IDLE.
- If char_valid and clear_req are asserted in the same cycle, the clear wins and char_ready=0. The character stays pending upstream.

## Structure
- Package lcd_pkg holds:
  - the state enum;
  - command constants CMD_FUNC_SET 0x38, CMD_DISP_OFF 0x08, CMD_CLEAR 0x01, CMD_ENTRY 0x06, CMD_DISP_ON 0x0C, CMD_LINE1 0x80, CMD_LINE2 0xC0;
  - the init ROM length, 7.
- Sub-module lcd_delay_timer has inputs load and load_value and output expired. It is shared by POWERUP and DELAY.

## Test plan
All scenarios run with POWERUP_CYCLES=20, SHORT_CYCLES=4, LONG_CYCLES=10, COLS=4, against the real send FSM.
- Reset release -> no cmd_ready for 20 cycles, then exactly seven cmd_ready pulses carrying 38, 38, 38, 08, 01, 06, 0C with rs=0. The gap after 01 is 10 delay cycles; init_done rises after the 0C delay.
- After init, offer 0x41 -> char_ready high at cycle 0; cmd_ready with rs=1 and data 0x41 at cycle 1; cmd_data stable through cmd_done; char_ready high again at cycle 9.
- Stream five characters -> after the 4th character, a command 0xC0 with rs=0 is issued before the 5th character is accepted.
- Stream eight characters -> 0xC0 after the 4th, 0x80 after the 8th (wrap to top).
- clear_req and char_valid together in IDLE -> 0x01 issued, char_ready=0, 10-cycle delay. The next character is written at row 0 / col 0 with no address command.
- Reset asserted during WAIT_DONE of an init byte -> all outputs return to reset values immediately. The full init sequence restarts after 20 cycles.
